cache_arbiter: RTL and testbench

//   Shares one Cache client port between two requesters: p0 (instruction fetch) and p1 (data).

---
 rtl/cache_arbiter_if.sv | 32 +++
 rtl/cache_arbiter.sv | 103 ++++++++++
 tb/tb_cache_arbiter.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/cache_arbiter_if.sv
// Requester ports p0/p1 plus the shared cache client port. The arbiter takes the
// slave view, the CPU-side masters and the cache together drive the master view.
interface cache_arbiter_if;
    logic        p0_req,          p1_req;
    logic [31:0] p0_address,      p1_address;
    logic [31:0] p0_data_in,      p1_data_in;
    logic [3:0]  p0_write_enable, p1_write_enable;
    logic        p0_ack,          p1_ack;
    logic [31:0] p0_data_out,     p1_data_out;
    logic        p0_err,          p1_err;
    logic [31:0] c_address;
    logic [31:0] c_data_in;
    logic [3:0]  c_write_enable;
    logic [31:0] c_data_out;
    logic        c_data_out_ready;
    logic        c_busy;
    logic        timeout_flag;

    modport slave (
        input  p0_req, p1_req, p0_address, p1_address, p0_data_in, p1_data_in,
               p0_write_enable, p1_write_enable, c_data_out, c_data_out_ready, c_busy,
        output p0_ack, p1_ack, p0_data_out, p1_data_out, p0_err, p1_err,
               c_address, c_data_in, c_write_enable, timeout_flag
    );

    modport master (
        output p0_req, p1_req, p0_address, p1_address, p0_data_in, p1_data_in,
               p0_write_enable, p1_write_enable, c_data_out, c_data_out_ready, c_busy,
        input  p0_ack, p1_ack, p0_data_out, p1_data_out, p0_err, p1_err,
               c_address, c_data_in, c_write_enable, timeout_flag
    );
endinterface

// File: rtl/cache_arbiter.sv
// Round-robin sharing of one cache client port between p0 (fetch) and p1 (data).
// One transaction in flight; a WAIT-state watchdog turns a silent cache into an error ack.
module cache_arbiter #(
    parameter int TIMEOUT_BITWIDTH = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    cache_arbiter_if.slave bus
);
    // Timeout fires at the end of the (2**W-1)-th WAIT cycle; count starts at 0.
    localparam logic [TIMEOUT_BITWIDTH-1:0] WD_LAST = {{(TIMEOUT_BITWIDTH-1){1'b1}}, 1'b0};

    typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT, ST_DONE} state_t;

    state_t                      state;
    logic [1:0]                  req, ack, err;
    logic [1:0][31:0]            addr, wdata, rdata;
    logic [1:0][3:0]             we;
    logic                        gnt, prio, nxt, accept;
    logic [TIMEOUT_BITWIDTH-1:0] wdog;
    logic [31:0]                 c_address, c_data_in;
    logic [3:0]                  c_write_enable;
    logic                        timeout_flag;

    assign req   = {bus.p1_req, bus.p0_req};
    assign addr  = {bus.p1_address, bus.p0_address};
    assign wdata = {bus.p1_data_in, bus.p0_data_in};
    assign we    = {bus.p1_write_enable, bus.p0_write_enable};

    assign bus.p0_ack         = ack[0];
    assign bus.p1_ack         = ack[1];
    assign bus.p0_err         = err[0];
    assign bus.p1_err         = err[1];
    assign bus.p0_data_out    = rdata[0];
    assign bus.p1_data_out    = rdata[1];
    assign bus.c_address      = c_address;
    assign bus.c_data_in      = c_data_in;
    assign bus.c_write_enable = c_write_enable;
    assign bus.timeout_flag   = timeout_flag;

    // prio names the requester that wins a tie
    assign nxt    = (req[0] && req[1]) ? prio : req[1];
    // A write completes on the first not-busy cycle; a read also needs ready.
    assign accept = !bus.c_busy && ((|c_write_enable) || bus.c_data_out_ready);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= ST_IDLE;
            gnt            <= 1'b0;
            prio           <= 1'b0;
            wdog           <= '0;
            ack            <= '0;
            err            <= '0;
            rdata          <= '0;
            c_address      <= '0;
            c_data_in      <= '0;
            c_write_enable <= '0;
            timeout_flag   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    c_write_enable <= '0;
                    if (|req) begin
                        gnt            <= nxt;
                        c_address      <= addr[nxt];
                        c_data_in      <= wdata[nxt];
                        c_write_enable <= we[nxt];
                        state          <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    // cache status here still reflects the previous address
                    wdog  <= '0;
                    state <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (accept) begin
                        if (c_write_enable == 4'h0) rdata[gnt] <= bus.c_data_out;
                        c_write_enable <= '0;
                        ack[gnt]       <= 1'b1;
                        state          <= ST_DONE;
                    end else if (wdog == WD_LAST) begin
                        c_write_enable <= '0;
                        ack[gnt]       <= 1'b1;
                        err[gnt]       <= 1'b1;
                        timeout_flag   <= 1'b1;
                        state          <= ST_DONE;
                    end else begin
                        wdog <= wdog + 1'b1;
                    end
                end
                ST_DONE: begin
                    ack            <= '0;
                    err            <= '0;
                    c_write_enable <= '0;
                    prio           <= ~gnt;
                    state          <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_cache_arbiter.sv
// Directed table of single transactions, round-robin / timeout / reset sequences,
// then random traffic against a transaction-level reference model.
module tb_cache_arbiter;
    localparam int TW          = 4;
    localparam int TO_WAIT     = (1 << TW) - 1;
    localparam int RAND_CYCLES = 3000;

    typedef struct {
        bit          id;
        logic [31:0] addr, wdata, rdata;
        logic [3:0]  we;
        int          stall, lat;
        logic [31:0] dout;
        logic        err;
    } vec_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    int   n_chk = 0;
    int   n_pass = 0;

    always #5 clk = ~clk;

    cache_arbiter_if bus();
    cache_arbiter #(.TIMEOUT_BITWIDTH(TW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic drive_req(input bit id, input logic r, input logic [31:0] a, input logic [31:0] d,
                             input logic [3:0] w);
        if (!id) begin
            bus.p0_req = r; bus.p0_address = a; bus.p0_data_in = d; bus.p0_write_enable = w;
        end else begin
            bus.p1_req = r; bus.p1_address = a; bus.p1_data_in = d; bus.p1_write_enable = w;
        end
    endtask

    function automatic logic ack_of(input bit id);
        return id ? bus.p1_ack : bus.p0_ack;
    endfunction
    function automatic logic err_of(input bit id);
        return id ? bus.p1_err : bus.p0_err;
    endfunction
    function automatic logic [31:0] dout_of(input bit id);
        return id ? bus.p1_data_out : bus.p0_data_out;
    endfunction
    function automatic logic [136:0] all_out();
        return {bus.p1_ack, bus.p0_ack, bus.p1_err, bus.p0_err, bus.timeout_flag, bus.c_write_enable,
                bus.p0_data_out, bus.p1_data_out, bus.c_address, bus.c_data_in};
    endfunction

    // One request from v.id; cache busy for v.stall WAIT cycles (ISSUE status is don't-care).
    task automatic run_txn(input vec_t v, input int idx);
        int lat;
        bit other;
        lat = -1;
        other = 1'b0;
        @(posedge clk); #1;
        drive_req(v.id, 1'b1, v.addr, v.wdata, v.we);
        bus.c_data_out = v.rdata; bus.c_data_out_ready = 1'b1; bus.c_busy = (v.stall > 0);
        for (int k = 0; k < 40 && lat < 0; k++) begin
            if (k > 0) begin @(posedge clk); #1; bus.c_busy = (k < v.stall + 2); end
            @(negedge clk);
            if (k == 1) chk($sformatf("v%0d c_address", idx), bus.c_address, v.addr);
            if (k == v.stall + 2) chk($sformatf("v%0d c_we_accept", idx), bus.c_write_enable, v.we);
            if (ack_of(!v.id)) other = 1'b1;
            if (ack_of(v.id)) begin
                lat = k;
                chk($sformatf("v%0d data_out", idx), dout_of(v.id), v.dout);
                chk($sformatf("v%0d err", idx), err_of(v.id), v.err);
                chk($sformatf("v%0d c_we_done", idx), bus.c_write_enable, 4'h0);
                chk($sformatf("v%0d timeout_flag", idx), bus.timeout_flag, 1'b1);
            end
        end
        chk($sformatf("v%0d latency", idx), lat, v.lat);
        chk($sformatf("v%0d other_ack", idx), other, 1'b0);
        @(posedge clk); #1;
        drive_req(v.id, 1'b0, v.addr, v.wdata, v.we);
        bus.c_busy = 1'b0;
        @(negedge clk);
        chk($sformatf("v%0d ack_err_drop", idx), {ack_of(v.id), err_of(v.id)}, 2'b00);
    endtask

    // Both requests held from cycle 0; expect alternating acks 4 cycles apart.
    task automatic run_pair(input string nm, input bit first, input int n_acks);
        int got_id[8];
        int got_cyc[8];
        int got_n;
        got_n = 0;
        for (int k = 0; k < 4 * n_acks; k++) begin
            if (k > 0) begin @(posedge clk); #1; end
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                if (ack_of(i[0]) && got_n < 8) begin
                    got_id[got_n] = i; got_cyc[got_n] = k; got_n++;
                end
            end
        end
        chk({nm, " ack_count"}, got_n, n_acks);
        for (int i = 0; i < n_acks && i < got_n; i++) begin
            chk($sformatf("%s ack%0d id", nm, i), got_id[i], int'(first ^ i[0]));
            chk($sformatf("%s ack%0d cycle", nm, i), got_cyc[i], 3 + 4 * i);
        end
        @(posedge clk); #1;
        bus.p0_req = 1'b0; bus.p1_req = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got time limit, expected summary before it");
        $fatal(1);
    end

    initial begin
        vec_t        tbl[6];
        logic [1:0]  r_req, s_ack, m_ack, m_err;
        logic [31:0] r_addr[2], r_wd[2], m_dout[2];
        logic [3:0]  r_we[2], m_we, m_cwe;
        logic [31:0] m_caddr, m_cdin, cdo;
        logic        m_flag, busy, rdy, ok;
        bit          m_active, m_g, m_last;
        int          m_free, m_ws, pct;

        //          id    addr          wdata         rdata         we    stall lat dout          err
        tbl[0] = '{1'b0, 32'h0000_0100, 32'h0,        32'h5555_5555, 4'h0, 99, 17, 32'hB0B0_0001, 1'b1};
        tbl[1] = '{1'b0, 32'h0000_0010, 32'h0,        32'h1234_5678, 4'h0, 0,  3,  32'h1234_5678, 1'b0};
        tbl[2] = '{1'b1, 32'h0000_0080, 32'hDEAD_BEEF, 32'h6666_6666, 4'h3, 5,  8,  32'hB0B0_0001, 1'b0};
        tbl[3] = '{1'b1, 32'h2000_0004, 32'h0,        32'hCAFE_F00D, 4'h0, 2,  5,  32'hCAFE_F00D, 1'b0};
        tbl[4] = '{1'b0, 32'h0000_0044, 32'h0BAD_F00D, 32'h7777_7777, 4'hF, 0,  3,  32'h1234_5678, 1'b0};
        tbl[5] = '{1'b0, 32'hFFFF_FFFC, 32'h0,        32'hA5A5_5A5A, 4'h0, 13, 16, 32'hA5A5_5A5A, 1'b0};

        drive_req(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        drive_req(1'b1, 1'b0, 32'h0, 32'h0, 4'h0);
        bus.c_data_out = 32'h0; bus.c_data_out_ready = 1'b0; bus.c_busy = 1'b0;

        #2 rst_n = 1'b0;
        @(negedge clk);
        chk("reset outputs", all_out(), '0);
        @(posedge clk); #1 rst_n = 1'b1;

        // round robin straight out of reset: p0 first
        @(posedge clk); #1;
        drive_req(1'b0, 1'b1, 32'h10, 32'h0, 4'h0);
        drive_req(1'b1, 1'b1, 32'h20, 32'h0, 4'h0);
        bus.c_data_out = 32'hB0B0_0001; bus.c_data_out_ready = 1'b1; bus.c_busy = 1'b0;
        run_pair("rr", 1'b0, 4);
        @(negedge clk);
        chk("rr timeout_flag", bus.timeout_flag, 1'b0);
        chk("rr p1_data_out", bus.p1_data_out, 32'hB0B0_0001);

        for (int i = 0; i < 6; i++) run_txn(tbl[i], i);

        // reset in WAIT; last served was p0, so only a reset pointer lets p0 win afterwards
        @(posedge clk); #1;
        drive_req(1'b1, 1'b1, 32'h300, 32'h0, 4'h0);
        bus.c_busy = 1'b1;
        @(posedge clk); #1;
        drive_req(1'b0, 1'b1, 32'h400, 32'h0, 4'h0);
        repeat (3) @(posedge clk);
        #3 rst_n = 1'b0;
        #1 chk("midwait reset outputs", all_out(), '0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        bus.c_busy = 1'b0; bus.c_data_out = 32'h0E0E_0E0E;
        run_pair("post_reset", 1'b0, 2);
        @(negedge clk);
        chk("post_reset p1_data_out", bus.p1_data_out, 32'h0E0E_0E0E);

        // random traffic
        @(posedge clk); #1;
        rst_n = 1'b0;
        drive_req(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        drive_req(1'b1, 1'b0, 32'h0, 32'h0, 4'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        r_req = '0; s_ack = '0;
        for (int i = 0; i < 2; i++) begin r_addr[i] = '0; r_wd[i] = '0; r_we[i] = '0; m_dout[i] = '0; end
        m_ack = '0; m_err = '0; m_flag = 1'b0; m_caddr = '0; m_cdin = '0; m_cwe = '0; m_we = '0;
        m_active = 1'b0; m_free = 0; m_ws = 0; m_g = 1'b0; m_last = 1'b1;
        for (int t = 0; t < RAND_CYCLES && (n_chk - n_pass) < 50; t++) begin
            if (t > 0) begin @(posedge clk); #1; end
            for (int i = 0; i < 2; i++) begin
                if ((s_ack[i] && $urandom_range(1, 0) == 1) || (!s_ack[i] && !r_req[i] && $urandom_range(3, 0) == 0)) begin
                    r_req[i] = 1'b1; r_addr[i] = $urandom; r_wd[i] = $urandom;
                    r_we[i]  = ($urandom_range(1, 0) == 1) ? 4'($urandom_range(15, 1)) : 4'h0;
                end else if (s_ack[i]) begin
                    r_req[i] = 1'b0;
                end
                drive_req(i[0], r_req[i], r_addr[i], r_wd[i], r_we[i]);
            end
            case ((t / 500) % 3)
                0:       pct = 25;
                1:       pct = 60;
                default: pct = 93;
            endcase
            busy = ($urandom_range(99, 0) < pct);
            rdy  = ($urandom_range(3, 0) != 0);
            cdo  = $urandom;
            bus.c_busy = busy; bus.c_data_out_ready = rdy; bus.c_data_out = cdo;

            @(negedge clk);
            chk($sformatf("rand t=%0d outputs", t), all_out(),
                {m_ack[1], m_ack[0], m_err[1], m_err[0], m_flag, m_cwe, m_dout[0], m_dout[1], m_caddr, m_cdin});
            s_ack = {bus.p1_ack, bus.p0_ack};

            // expected outputs for the next cycle
            m_ack = '0; m_err = '0;
            if (m_active) begin
                if (t >= m_ws) begin
                    ok = (m_we == 4'h0) ? (!busy && rdy) : !busy;
                    if (ok || (t - m_ws == TO_WAIT - 1)) begin
                        if (ok && m_we == 4'h0) m_dout[m_g] = cdo;
                        m_ack[m_g] = 1'b1;
                        if (!ok) begin m_err[m_g] = 1'b1; m_flag = 1'b1; end
                        m_cwe = 4'h0; m_active = 1'b0; m_free = t + 2; m_last = m_g;
                    end
                end
            end else if (t >= m_free && (r_req[0] || r_req[1])) begin
                m_g      = (r_req[0] && r_req[1]) ? !m_last : r_req[1];
                m_active = 1'b1;
                m_ws     = t + 2;
                m_caddr  = r_addr[m_g]; m_cdin = r_wd[m_g]; m_we = r_we[m_g]; m_cwe = r_we[m_g];
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
